burst_arbiter: RTL and testbench

BURST_ARBITER -- requirements
Module: burst_arbiter

---
 rtl/burst_arbiter.sv | 168 ++++++++++++++++
 tb/tb_burst_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_arbiter.sv
// Round-robin arbiter that hands one shared burst slave port to one of two
// masters for the duration of a whole write or read burst.
module burst_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_m0_wr,
  input  logic              io_m0_rd,
  input  logic [ADDR_W-1:0] io_m0_address,
  input  logic [LEN_W-1:0]  io_m0_length,
  input  logic [DATA_W-1:0] io_m0_wdata,
  output logic [DATA_W-1:0] io_m0_rdata,
  output logic              io_m0_ready,
  output logic              io_m0_rddatavalid,
  output logic              io_m0_grant,
  input  logic              io_m1_wr,
  input  logic              io_m1_rd,
  input  logic [ADDR_W-1:0] io_m1_address,
  input  logic [LEN_W-1:0]  io_m1_length,
  input  logic [DATA_W-1:0] io_m1_wdata,
  output logic [DATA_W-1:0] io_m1_rdata,
  output logic              io_m1_ready,
  output logic              io_m1_rddatavalid,
  output logic              io_m1_grant,
  output logic              io_s_wr,
  output logic              io_s_rd,
  output logic [ADDR_W-1:0] io_s_address,
  output logic [LEN_W-1:0]  io_s_length,
  output logic [DATA_W-1:0] io_s_wdata,
  input  logic [DATA_W-1:0] io_s_rdata,
  input  logic              io_s_ready,
  input  logic              io_s_rddatavalid
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

  state_t            state;
  logic              owner;
  logic              pointer;
  logic [LEN_W:0]    remaining;
  logic              grant0;
  logic              grant1;
  logic              cmd_wr;
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_address;
  logic [LEN_W-1:0]  cmd_length;

  logic              req0;
  logic              req1;
  logic              winner;
  logic              win_wr;
  logic [ADDR_W-1:0] win_address;
  logic [LEN_W-1:0]  win_length;
  logic              owner_req;
  logic [LEN_W:0]    beats;

  assign req0        = io_m0_wr | io_m0_rd;
  assign req1        = io_m1_wr | io_m1_rd;
  assign winner      = (req0 & req1) ? pointer : req1;
  assign win_wr      = winner ? io_m1_wr : io_m0_wr;
  assign win_address = winner ? io_m1_address : io_m0_address;
  assign win_length  = winner ? io_m1_length : io_m0_length;
  assign owner_req   = owner ? req1 : req0;
  assign beats       = (cmd_length == '0) ? ONE : {1'b0, cmd_length};

  // Command fields are captured when the burst is granted so they stay stable while the slave stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      pointer     <= 1'b0;
      remaining   <= '0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_address <= '0;
      cmd_length  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state       <= CMD;
            owner       <= winner;
            grant0      <= ~winner;
            grant1      <= winner;
            cmd_wr      <= win_wr;
            cmd_rd      <= ~win_wr;
            cmd_address <= win_address;
            cmd_length  <= win_length;
          end
        end
        CMD: begin
          if (io_s_ready) begin
            pointer     <= ~owner;
            cmd_wr      <= 1'b0;
            cmd_rd      <= 1'b0;
            cmd_address <= '0;
            cmd_length  <= '0;
            if (cmd_wr) begin
              remaining <= beats - ONE;
              if (beats == ONE) begin
                state  <= IDLE;
                grant0 <= 1'b0;
                grant1 <= 1'b0;
              end else begin
                state <= WRITE;
              end
            end else begin
              remaining <= beats;
              state     <= READ;
            end
          end else if (!owner_req) begin
            state       <= IDLE;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            cmd_wr      <= 1'b0;
            cmd_rd      <= 1'b0;
            cmd_address <= '0;
            cmd_length  <= '0;
          end
        end
        WRITE: begin
          if (io_s_ready) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state  <= IDLE;
              grant0 <= 1'b0;
              grant1 <= 1'b0;
            end
          end
        end
        READ: begin
          if (io_s_rddatavalid) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state  <= IDLE;
              grant0 <= 1'b0;
              grant1 <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_m0_grant       = grant0;
  assign io_m1_grant       = grant1;
  assign io_m0_rdata       = io_s_rdata;
  assign io_m1_rdata       = io_s_rdata;
  assign io_m0_ready       = io_s_ready & grant0;
  assign io_m1_ready       = io_s_ready & grant1;
  assign io_m0_rddatavalid = io_s_rddatavalid & grant0 & (state == READ);
  assign io_m1_rddatavalid = io_s_rddatavalid & grant1 & (state == READ);
  assign io_s_wr           = cmd_wr;
  assign io_s_rd           = cmd_rd;
  assign io_s_address      = cmd_address;
  assign io_s_length       = cmd_length;
  assign io_s_wdata        = ((state == CMD) || (state == WRITE)) ?
                             (owner ? io_m1_wdata : io_m0_wdata) : '0;

endmodule

// File: tb/tb_burst_arbiter.sv
// Bench for burst_arbiter: directed cycle tables, hand-written corner sequences
// and a randomized run against a transaction-level model of the arbiter.
module tb_burst_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_wr = 1'b0, m0_rd = 1'b0, m1_wr = 1'b0, m1_rd = 1'b0;
  logic [3:0]  m0_addr = '0, m0_len = '0, m1_addr = '0, m1_len = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic        s_ready = 1'b0, s_rdv = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, s_wdata;
  logic        m0_ready, m1_ready, m0_rdv, m1_rdv, m0_grant, m1_grant;
  logic        s_wr, s_rd;
  logic [3:0]  s_addr, s_len;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        m0_wr, m0_rd, m1_wr, m1_rd;
    logic        s_ready, s_rdv;
    logic [31:0] wdata;
    logic        e_wr, e_rd;
    logic [3:0]  e_addr, e_len;
    logic [31:0] e_wdata;
    logic        e_g0, e_g1, e_r0, e_r1, e_v0, e_v1;
  } vec_t;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;
  localparam logic [31:0] WE = 32'hE0E0_0005;

  // Transaction-level model: who holds the port, whether its command is still pending, beats left.
  int          mdl_owner, mdl_left, mdl_ptr, mdl_total, win;
  logic [3:0]  mdl_addr, mdl_len;
  bit          mdl_cmd, mdl_write;
  bit   [1:0]  pend, p_wr, p_rd;
  logic [3:0]  p_addr [2];
  logic [3:0]  p_len  [2];
  logic        e_wr, e_rd, e_g0, e_g1, e_v0, e_v1;
  logic [7:0]  e_al;
  logic [31:0] e_wd;

  burst_arbiter dut (
    .clock(clock), .reset(reset),
    .io_m0_wr(m0_wr), .io_m0_rd(m0_rd), .io_m0_address(m0_addr), .io_m0_length(m0_len),
    .io_m0_wdata(m0_wdata), .io_m0_rdata(m0_rdata), .io_m0_ready(m0_ready),
    .io_m0_rddatavalid(m0_rdv), .io_m0_grant(m0_grant),
    .io_m1_wr(m1_wr), .io_m1_rd(m1_rd), .io_m1_address(m1_addr), .io_m1_length(m1_len),
    .io_m1_wdata(m1_wdata), .io_m1_rdata(m1_rdata), .io_m1_ready(m1_ready),
    .io_m1_rddatavalid(m1_rdv), .io_m1_grant(m1_grant),
    .io_s_wr(s_wr), .io_s_rd(s_rd), .io_s_address(s_addr), .io_s_length(s_len),
    .io_s_wdata(s_wdata), .io_s_rdata(s_rdata), .io_s_ready(s_ready),
    .io_s_rddatavalid(s_rdv)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " ctl"}, 64'({s_wr, s_rd, m0_grant, m1_grant, m0_ready, m1_ready, m0_rdv, m1_rdv}), 64'd0);
    checkOutput({tag, " addr/len"}, 64'({s_addr, s_len}), 64'd0);
    checkOutput({tag, " wdata"}, 64'(s_wdata), 64'd0);
  endtask

  task automatic doReset();
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
    s_ready = 1'b0; s_rdv = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    m0_wr    = v.m0_wr;
    m0_rd    = v.m0_rd;
    m1_wr    = v.m1_wr;
    m1_rd    = v.m1_rd;
    s_ready  = v.s_ready;
    s_rdv    = v.s_rdv;
    m0_wdata = v.wdata;
    m1_wdata = ~v.wdata;
    s_rdata  = v.wdata ^ 32'h5A5A_5A5A;
  endtask

  task automatic abortWrite();
    m0_wr = 1'b1; m0_addr = 4'd6; m0_len = 4'd4; s_ready = 1'b1; s_rdv = 1'b0;
    step();
    step();
    m0_wr = 1'b0;
    step();
    #1;
    checkOutput("abort midburst grant", 64'({m0_grant, s_wr}), 64'(2'b10));
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input int rst, input int m0w, input int m0r, input int m1w,
                              input int m1r, input int rdy, input int rdv, input logic [31:0] wd,
                              input int ewr, input int erd, input int ea, input int el,
                              input logic [31:0] ewd, input int g0, input int g1,
                              input int r0, input int r1, input int v0, input int v1);
    vec_t v;
    v.rst = rst[0];   v.m0_wr = m0w[0]; v.m0_rd = m0r[0]; v.m1_wr = m1w[0]; v.m1_rd = m1r[0];
    v.s_ready = rdy[0]; v.s_rdv = rdv[0]; v.wdata = wd;
    v.e_wr = ewr[0];  v.e_rd = erd[0];  v.e_addr = ea[3:0]; v.e_len = el[3:0]; v.e_wdata = ewd;
    v.e_g0 = g0[0];   v.e_g1 = g1[0];   v.e_r0 = r0[0]; v.e_r1 = r1[0];
    v.e_v0 = v0[0];   v.e_v1 = v1[0];
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   gcount;
    int   kind;

    $display("[TB] burst_arbiter bench starting");
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checkQuiet("reset");

    m0_addr = 4'd6; m0_len = 4'd4; m1_addr = 4'd9; m1_len = 4'd4;
    // m0 four-beat write A..D, then a stray rddatavalid in IDLE
    tbl.push_back(mk(0,1,0,0,0,1,0,WA, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,0,WA, 1,0,6,4,WA,    1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,WB, 0,0,0,0,WB,    1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,WC, 0,0,0,0,WC,    1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,WD, 0,0,0,0,WD,    1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1,WE, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    // reset, simultaneous reads: m0 first, then m1 with a gappy valid pattern, then a tie again
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,1,0,0, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,1,0,0, 0,1,6,4,32'd0, 1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,1,0, 0,0,0,0,32'd0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0, 0,0,0,0,32'd0, 1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,1,0, 0,0,0,0,32'd0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,1,1,0, 0,0,0,0,32'd0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,1,1,0, 0,0,0,0,32'd0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,1,1,0, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,1,0,0, 0,1,9,4,32'hFFFF_FFFF, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,1,0, 0,0,0,0,32'd0, 0,1,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,1,0,0, 0,0,0,0,32'd0, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,1,0, 0,0,0,0,32'd0, 0,1,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,1,1,0, 0,0,0,0,32'd0, 0,1,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,1,0,0, 0,0,0,0,32'd0, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,1,0, 0,0,0,0,32'd0, 0,1,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,1,0,0,0, 0,0,0,0,32'd0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,0,0, 0,1,6,4,32'd0, 1,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("vec%0d ctl", i),
                  64'({s_wr, s_rd, m0_grant, m1_grant, m0_ready, m1_ready, m0_rdv, m1_rdv}),
                  64'({tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_g0, tbl[i].e_g1,
                       tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_v0, tbl[i].e_v1}));
      checkOutput($sformatf("vec%0d addr/len", i), 64'({s_addr, s_len}),
                  64'({tbl[i].e_addr, tbl[i].e_len}));
      checkOutput($sformatf("vec%0d wdata", i), 64'(s_wdata), 64'(tbl[i].e_wdata));
      step();
    end

    // slave stalls the command for three cycles
    doReset();
    m1_wr = 1'b1; m1_addr = 4'd3; m1_len = 4'd2; m1_wdata = 32'h3333_0000; s_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall%0d ctl", i), 64'({s_wr, s_rd, m1_grant, m1_ready}), 64'(4'b1010));
      checkOutput($sformatf("stall%0d addr/len", i), 64'({s_addr, s_len}), 64'({4'd3, 4'd2}));
      step();
    end
    s_ready = 1'b1;
    #1;
    checkOutput("stall accept", 64'({s_wr, s_addr, s_wdata}), 64'({1'b1, 4'd3, 32'h3333_0000}));
    step();
    m1_wr = 1'b0; m1_wdata = 32'h3333_0001;
    #1;
    checkOutput("stall beat1", 64'({s_wr, m1_grant, s_wdata}), 64'({1'b0, 1'b1, 32'h3333_0001}));
    step();
    #1;
    checkOutput("stall done", 64'({m1_grant, m0_grant}), 64'd0);

    // length 0 is a single beat; length 15 holds the grant for 15 beats
    doReset();
    m0_wr = 1'b1; m0_addr = 4'd5; m0_len = 4'd0; s_ready = 1'b1;
    step();
    #1;
    checkOutput("len0 cmd", 64'({s_wr, s_len, m0_grant}), 64'({1'b1, 4'd0, 1'b1}));
    step();
    m0_wr = 1'b0;
    #1;
    checkOutput("len0 idle", 64'({m0_grant, s_wr}), 64'd0);
    m0_wr = 1'b1; m0_len = 4'd15;
    step();
    #1;
    checkOutput("len15 cmd", 64'({s_wr, s_len}), 64'({1'b1, 4'd15}));
    gcount = 0;
    for (int c = 0; c < 40 && m0_grant; c++) begin
      gcount++;
      step();
      m0_wr = 1'b0;
      #1;
    end
    checkOutput("len15 beats", 64'(gcount), 64'd15);

    // reset in the middle of a write burst, then a fresh m1 read
    doReset();
    abortWrite();
    #1;
    checkQuiet("abort");
    m1_rd = 1'b1; m1_addr = 4'd7; m1_len = 4'd1; s_ready = 1'b1;
    step();
    #1;
    checkOutput("fresh m1 cmd", 64'({s_rd, m1_grant, m0_grant, s_addr}), 64'({1'b1, 1'b1, 1'b0, 4'd7}));
    step();
    m1_rd = 1'b0; s_rdv = 1'b1;
    #1;
    checkOutput("fresh m1 beat", 64'({m1_rdv, m0_rdv}), 64'(2'b10));
    step();
    s_rdv = 1'b0;
    #1;
    checkOutput("fresh m1 done", 64'(m1_grant), 64'd0);
    abortWrite();
    m0_wr = 1'b1; m1_rd = 1'b1; s_ready = 1'b0;
    step();
    #1;
    checkOutput("pointer after reset", 64'({m0_grant, m1_grant, s_wr}), 64'(3'b101));

    doReset();
    mdl_owner = -1; mdl_cmd = 1'b0; mdl_write = 1'b0; mdl_left = 0; mdl_ptr = 0;
    pend = 2'b00; p_wr = 2'b00; p_rd = 2'b00;
    p_addr[0] = '0; p_addr[1] = '0; p_len[0] = '0; p_len[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && $urandom_range(0, 3) == 0) begin
          pend[x]   = 1'b1;
          kind      = int'($urandom_range(0, 4));
          p_wr[x]   = (kind < 2) || (kind == 4);
          p_rd[x]   = (kind >= 2);
          p_addr[x] = 4'($urandom);
          p_len[x]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        end
      end
      m0_wr = pend[0] & p_wr[0]; m0_rd = pend[0] & p_rd[0];
      m1_wr = pend[1] & p_wr[1]; m1_rd = pend[1] & p_rd[1];
      m0_addr = p_addr[0]; m0_len = p_len[0]; m1_addr = p_addr[1]; m1_len = p_len[1];
      m0_wdata = $urandom; m1_wdata = $urandom; s_rdata = $urandom;
      s_ready = ($urandom_range(0, 9) < 7);
      s_rdv   = ($urandom_range(0, 1) == 1);
      #1;

      e_g0 = (mdl_owner == 0);
      e_g1 = (mdl_owner == 1);
      e_wr = mdl_cmd & mdl_write;
      e_rd = mdl_cmd & !mdl_write;
      e_al = mdl_cmd ? {mdl_addr, mdl_len} : 8'd0;
      e_wd = ((mdl_owner >= 0) && (mdl_cmd || mdl_write)) ? ((mdl_owner == 1) ? m1_wdata : m0_wdata) : 32'd0;
      e_v0 = e_g0 && !mdl_cmd && !mdl_write && s_rdv;
      e_v1 = e_g1 && !mdl_cmd && !mdl_write && s_rdv;
      checkOutput($sformatf("rand%0d ctl", cyc),
                  64'({s_wr, s_rd, m0_grant, m1_grant, m0_ready, m1_ready, m0_rdv, m1_rdv}),
                  64'({e_wr, e_rd, e_g0, e_g1, e_g0 & s_ready, e_g1 & s_ready, e_v0, e_v1}));
      checkOutput($sformatf("rand%0d addr/len", cyc), 64'({s_addr, s_len}), 64'(e_al));
      checkOutput($sformatf("rand%0d wdata", cyc), 64'(s_wdata), 64'(e_wd));
      checkOutput($sformatf("rand%0d rdata", cyc), {m0_rdata, m1_rdata}, {s_rdata, s_rdata});

      if (mdl_owner < 0) begin
        if (pend != 2'b00) begin
          win       = (pend == 2'b11) ? mdl_ptr : (pend[1] ? 1 : 0);
          mdl_owner = win;
          mdl_cmd   = 1'b1;
          mdl_write = p_wr[win];
          mdl_addr  = p_addr[win];
          mdl_len   = p_len[win];
        end
      end else if (mdl_cmd) begin
        if (s_ready) begin
          pend[mdl_owner] = 1'b0;
          mdl_ptr   = 1 - mdl_owner;
          mdl_cmd   = 1'b0;
          mdl_total = (mdl_len == 4'd0) ? 1 : int'(mdl_len);
          mdl_left  = mdl_write ? mdl_total - 1 : mdl_total;
          if (mdl_left == 0) mdl_owner = -1;
        end
      end else if (mdl_write ? s_ready : s_rdv) begin
        mdl_left--;
        if (mdl_left == 0) mdl_owner = -1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
